// File: rtl/mux_l1_tx.sv
// Four-lane to single-stream transmit serializer: captures all lanes once per
// frame and emits them round-robin 0,1,2,3 on clk_4f, IDLE_BYTE in empty slots.
module mux_l1_tx #(
    parameter int unsigned    BW        = 8,
    parameter logic [BW-1:0]  IDLE_BYTE = 8'hBC
) (
    input  logic          clk_4f,
    input  logic          reset_L,
    input  logic          enable,
    input  logic [BW-1:0] data_0,
    input  logic [BW-1:0] data_1,
    input  logic [BW-1:0] data_2,
    input  logic [BW-1:0] data_3,
    input  logic          valid_0,
    input  logic          valid_1,
    input  logic          valid_2,
    input  logic          valid_3,
    output logic          load_strobe,
    output logic [BW-1:0] data_out,
    output logic          valid_out,
    output logic [1:0]    lane_out
);

    logic [1:0]    r_phase;
    logic [BW-1:0] r_bank_data [4];
    logic [3:0]    r_bank_valid;

    logic [BW-1:0] w_lane_data [4];
    logic [3:0]    w_lane_valid;
    logic          w_capture;

    always_comb begin
        w_lane_data[0] = data_0;
        w_lane_data[1] = data_1;
        w_lane_data[2] = data_2;
        w_lane_data[3] = data_3;
        w_lane_valid   = {valid_3, valid_2, valid_1, valid_0};
    end

    assign w_capture   = (r_phase == 2'd3);
    assign load_strobe = w_capture & enable & reset_L;

    // The slot closed by an edge belongs to the lane indexed by the pre-edge
    // phase, so lane i of a frame captured at edge k leaves at edge k+1+i and
    // lane 3 reads the bank before the same-edge capture overwrites it.
    always_ff @(posedge clk_4f) begin
        if (!reset_L) begin
            r_phase      <= 2'd3;
            r_bank_valid <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_bank_data[i] <= '0;
            end
            data_out  <= IDLE_BYTE;
            valid_out <= 1'b0;
            lane_out  <= 2'd0;
        end else if (enable) begin
            r_phase <= r_phase + 2'd1;
            if (w_capture) begin
                r_bank_valid <= w_lane_valid;
                for (int unsigned i = 0; i < 4; i++) begin
                    r_bank_data[i] <= w_lane_data[i];
                end
            end
            data_out  <= r_bank_valid[r_phase] ? r_bank_data[r_phase] : IDLE_BYTE;
            valid_out <= r_bank_valid[r_phase];
            lane_out  <= r_phase;
        end else begin
            data_out  <= IDLE_BYTE;
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_l1_tx.sv
// Scoreboard bench for mux_l1_tx: the driver queues one expected slot per
// cycle, an independent monitor pops and compares after each clock edge.
module tb_mux_l1_tx;

    logic       clk_4f = 1'b0;
    logic       reset_L = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] data_0 = '0, data_1 = '0, data_2 = '0, data_3 = '0;
    logic       valid_0 = 1'b0, valid_1 = 1'b0, valid_2 = 1'b0, valid_3 = 1'b0;
    logic       load_strobe;
    logic [7:0] data_out;
    logic       valid_out;
    logic [1:0] lane_out;

    typedef struct packed {
        logic       ls;
        logic [7:0] d;
        logic       v;
        logic [1:0] l;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Frame previously captured; its lane 3 is emitted during the next load cycle.
    logic [31:0] prev_dw = '0;
    logic [3:0]  prev_vw = '0;

    mux_l1_tx #(.BW(8), .IDLE_BYTE(8'hBC)) dut (
        .clk_4f      (clk_4f),
        .reset_L     (reset_L),
        .enable      (enable),
        .data_0      (data_0),
        .data_1      (data_1),
        .data_2      (data_2),
        .data_3      (data_3),
        .valid_0     (valid_0),
        .valid_1     (valid_1),
        .valid_2     (valid_2),
        .valid_3     (valid_3),
        .load_strobe (load_strobe),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .lane_out    (lane_out)
    );

    always #5 clk_4f = ~clk_4f;

    function automatic logic [7:0] slot_byte(input logic [31:0] dw, input logic [3:0] vw,
                                             input int unsigned lane);
        return vw[lane] ? dw[8*lane +: 8] : 8'hBC;
    endfunction

    // One clock cycle: drive inputs, queue what load_strobe must be in this
    // cycle and what the registered outputs must be after its closing edge.
    task automatic cyc(input logic rst, input logic en, input logic [31:0] dw,
                       input logic [3:0] vw, input logic els, input logic [7:0] ed,
                       input logic ev, input logic [1:0] el);
        reset_L = rst;
        enable  = en;
        data_0  = dw[7:0];
        data_1  = dw[15:8];
        data_2  = dw[23:16];
        data_3  = dw[31:24];
        {valid_3, valid_2, valid_1, valid_0} = vw;
        exp_q.push_back('{ls: els, d: ed, v: ev, l: el});
        @(posedge clk_4f);
        #2;
    endtask

    // Full frame starting at a load cycle; junk=1 scrambles inputs off-strobe.
    task automatic frame(input logic [31:0] dw, input logic [3:0] vw, input bit junk);
        cyc(1'b1, 1'b1, dw, vw, 1'b1, slot_byte(prev_dw, prev_vw, 3), prev_vw[3], 2'd3);
        for (int unsigned i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, junk ? 32'($urandom) : dw, junk ? 4'($urandom) : vw,
                1'b0, slot_byte(dw, vw, i), vw[i], 2'(i));
        end
        prev_dw = dw;
        prev_vw = vw;
    endtask

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        logic ls;
        forever begin
            @(negedge clk_4f);
            if (exp_q.size() > 0) begin
                ls = load_strobe;
                @(posedge clk_4f);
                #1;
                e = exp_q.pop_front();
                cmp("load_strobe", {7'd0, ls}, {7'd0, e.ls});
                cmp("data_out", data_out, e.d);
                cmp("valid_out", {7'd0, valid_out}, {7'd0, e.v});
                cmp("lane_out", {6'd0, lane_out}, {6'd0, e.l});
            end
        end
    end

    initial begin : driver
        int unsigned guard;
        @(posedge clk_4f);
        #2;
        // Reset with enable high: strobe must stay low, outputs at reset values.
        repeat (2) cyc(1'b0, 1'b1, 32'h0, 4'h0, 1'b0, 8'hBC, 1'b0, 2'd0);

        // Test 1: all lanes valid, held; first load slot emits the empty reset bank.
        frame(32'h44332211, 4'hF, 1'b0);
        frame(32'h44332211, 4'hF, 1'b0);
        // Test 2: lanes 1 and 3 invalid.
        frame(32'hA3A2A1A0, 4'b0101, 1'b0);
        // Test 3: inputs valid only in the strobe cycle.
        frame(32'h58575655, 4'hF, 1'b1);

        // Test 4: pause after lane 1, resume with lane 2 of the same frame.
        cyc(1'b1, 1'b1, 32'h6C6B6A69, 4'hF, 1'b1, 8'h58, 1'b1, 2'd3);
        cyc(1'b1, 1'b1, 32'hDEADBEEF, 4'h0, 1'b0, 8'h69, 1'b1, 2'd0);
        cyc(1'b1, 1'b1, 32'hDEADBEEF, 4'h0, 1'b0, 8'h6A, 1'b1, 2'd1);
        repeat (3) cyc(1'b1, 1'b0, 32'hCAFEF00D, 4'hF, 1'b0, 8'hBC, 1'b0, 2'd1);
        cyc(1'b1, 1'b1, 32'h0, 4'h0, 1'b0, 8'h6B, 1'b1, 2'd2);
        prev_dw = 32'h6C6B6A69;
        prev_vw = 4'hF;
        // Pause right at a load slot: no strobe, no capture while disabled.
        cyc(1'b1, 1'b0, 32'h11111111, 4'hF, 1'b0, 8'hBC, 1'b0, 2'd2);
        frame(32'h7D7C7B7A, 4'hF, 1'b0);

        // Test 5: reset after lane 2; lane 3 (7D) must never appear.
        cyc(1'b0, 1'b1, 32'h0, 4'h0, 1'b0, 8'hBC, 1'b0, 2'd0);
        prev_dw = '0;
        prev_vw = '0;
        frame(32'h84838281, 4'b1010, 1'b0);

        // Test 6: random frames against the frame-queue reference.
        for (int unsigned f = 0; f < 1000; f++) begin
            frame(32'($urandom), 4'($urandom_range(0, 15)), 1'b1);
        end
        frame(32'h0, 4'h0, 1'b0);

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk_4f);
            guard++;
        end
        #3;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d slots unchecked, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
